// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DISCARD
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0010;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry output buffer holding a fetched instruction and its PC until decode consumes it.
module fetch_out_buf #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             consume,
    input  logic             flush,
    input  logic [31:0]      load_instr,
    input  logic [WIDTH-1:0] load_pc,
    output logic             valid,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] instr_pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid    <= 1'b0;
            instr    <= '0;
            instr_pc <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            instr    <= load_instr;
            instr_pc <= load_pc;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and fetch controller over a req/gnt/rvalid instruction-memory interface.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects load TRAP_VECTOR and pulse misalign_trap.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(DEFAULT_TRAP_VECTOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             stall,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             misalign_trap
);

    fetch_state_t     state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] redirect_pc;
    logic             misaligned;
    logic             load;
    logic             consume;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned  = (redirect_target[1:0] != 2'b00);
    assign redirect_pc = misaligned ? TRAP_VECTOR : redirect_target;
`else
    logic unused_bits;
    assign misaligned  = 1'b0;
    assign redirect_pc = {redirect_target[WIDTH-1:2], 2'b00};
    assign unused_bits = ^{redirect_target[1:0], TRAP_VECTOR};
`endif

    // Request depends on this cycle's stall so a consumed buffer can be refilled without a bubble.
    assign consume   = instr_valid && !stall;
    assign imem_req  = (state == REQ) && (!instr_valid || !stall);
    assign imem_addr = pc;
    assign load      = (state == WAIT) && imem_rvalid && !redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pc            <= RESET_VECTOR;
            misalign_trap <= 1'b0;
        end else begin
            misalign_trap <= redirect_valid && misaligned;

            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (load) begin
                pc <= pc + WIDTH'(INSTR_BYTES);
            end

            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_req && imem_gnt) begin
                        state <= redirect_valid ? DISCARD : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= REQ;
                    end else if (redirect_valid) begin
                        state <= DISCARD;
                    end
                end
                // A redirect here only moves pc; the pending response still retires the discard.
                DISCARD: begin
                    if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .consume   (consume),
        .flush     (redirect_valid),
        .load_instr(imem_rdata),
        .load_pc   (pc),
        .valid     (instr_valid),
        .instr     (instr),
        .instr_pc  (instr_pc)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, reset corner case, randomized model check.
module tb_fetch_sequencer;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [31:0] TRAP_VEC = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign_trap;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .WIDTH       (32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (TRAP_VEC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .misalign_trap  (misalign_trap)
    );

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        trap;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                                input logic g, input logic v, input logic [31:0] d,
                                input logic rq, input logic [31:0] a, input logic iv,
                                input logic [31:0] i, input logic [31:0] p, input logic tr);
        vec_t x;
        x.stall = s; x.redir = r; x.tgt = t; x.gnt = g; x.rvalid = v; x.rdata = d;
        x.req = rq; x.addr = a; x.iv = iv; x.instr = i; x.ipc = p; x.trap = tr;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] t,
                         input logic g, input logic v, input logic [31:0] d);
        stall = s; redirect_valid = r; redirect_target = t;
        imem_gnt = g; imem_rvalid = v; imem_rdata = d;
    endtask

    task automatic check_out(input string tag, input logic rq, input logic [31:0] a,
                             input logic iv, input logic [31:0] i, input logic [31:0] p,
                             input logic tr);
        check({tag, " imem_req"}, 32'(imem_req), 32'(rq));
        if (rq) check({tag, " imem_addr"}, imem_addr, a);
        check({tag, " instr_valid"}, 32'(instr_valid), 32'(iv));
        if (iv) begin
            check({tag, " instr"}, instr, i);
            check({tag, " instr_pc"}, instr_pc, p);
        end
        check({tag, " misalign_trap"}, 32'(misalign_trap), 32'(tr));
    endtask

    // Reference model state, transaction-level view of the fetch pipeline.
    logic [31:0] m_pc, m_bi, m_bp, etgt;
    bit          m_warm, m_pend, m_stale, m_bv, m_trap;
    int unsigned m_delay;
    bit          r_stall, r_redir, r_gnt, r_rv, exp_req, acc, resp, live, mis;
    logic [31:0] r_tgt, r_rdata;

    initial begin
        logic [31:0] xa;
        logic        xt;
        xa = TRAP_EN ? TRAP_VEC : 32'h0000_0100;
        xt = TRAP_EN;

        vecs[0]  = mk(0,0,0,0,0,0,               0,0,0,0,0,0);
        vecs[1]  = mk(0,0,0,1,0,0,               1,32'h0,0,0,0,0);
        vecs[2]  = mk(0,0,0,0,1,32'hA000_0000,   0,0,0,0,0,0);
        vecs[3]  = mk(0,0,0,1,0,0,               1,32'h4,1,32'hA000_0000,32'h0,0);
        vecs[4]  = mk(0,0,0,0,1,32'hA000_0001,   0,0,0,0,0,0);
        for (int k = 5; k <= 9; k++)
            vecs[k] = mk(1,0,0,1,0,0,            0,0,1,32'hA000_0001,32'h4,0);
        vecs[10] = mk(0,0,0,1,0,0,               1,32'h8,1,32'hA000_0001,32'h4,0);
        vecs[11] = mk(0,0,0,0,1,32'hA000_0002,   0,0,0,0,0,0);
        vecs[12] = mk(0,0,0,1,0,0,               1,32'hC,1,32'hA000_0002,32'h8,0);
        vecs[13] = mk(0,1,32'h100,0,0,0,         0,0,0,0,0,0);
        vecs[14] = mk(0,0,0,0,0,0,               0,0,0,0,0,0);
        vecs[15] = mk(0,0,0,0,1,32'hA000_0003,   0,0,0,0,0,0);
        vecs[16] = mk(0,0,0,1,0,0,               1,32'h100,0,0,0,0);
        vecs[17] = mk(0,0,0,0,1,32'hA000_0004,   0,0,0,0,0,0);
        vecs[18] = mk(0,0,0,1,0,0,               1,32'h104,1,32'hA000_0004,32'h100,0);
        vecs[19] = mk(1,1,32'h200,0,1,32'hA000_0005, 0,0,0,0,0,0);
        vecs[20] = mk(1,0,0,0,0,0,               1,32'h200,0,0,0,0);
        vecs[21] = mk(0,0,0,1,0,0,               1,32'h200,0,0,0,0);
        vecs[22] = mk(0,0,0,0,1,32'hA000_0006,   0,0,0,0,0,0);
        vecs[23] = mk(1,0,0,0,0,0,               0,0,1,32'hA000_0006,32'h200,0);
        vecs[24] = mk(1,1,32'h102,0,0,0,         0,0,1,32'hA000_0006,32'h200,0);
        vecs[25] = mk(0,0,0,0,0,0,               1,xa,0,0,0,xt);
        vecs[26] = mk(0,0,0,1,0,0,               1,xa,0,0,0,0);
        vecs[27] = mk(0,0,0,0,1,32'hA000_0007,   0,0,0,0,0,0);
        vecs[28] = mk(0,0,0,0,0,0,               1,xa + 32'h4,1,32'hA000_0007,xa,0);

        rst = 1'b0;
        drive(0,0,0,0,0,0);
        repeat (2) @(negedge clk);
        #1 check_out("reset", 0, 0, 0, 0, 0, 0);
        check("reset instr", instr, 32'h0);
        check("reset instr_pc", instr_pc, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 29; k++) begin
            drive(vecs[k].stall, vecs[k].redir, vecs[k].tgt, vecs[k].gnt, vecs[k].rvalid, vecs[k].rdata);
            #1 check_out($sformatf("vec%0d", k), vecs[k].req, vecs[k].addr, vecs[k].iv,
                         vecs[k].instr, vecs[k].ipc, vecs[k].trap);
            @(negedge clk);
        end

        // Reset while a response is outstanding; the stale response must be ignored.
        drive(0,0,0,1,0,0);
        #1 check_out("rstseq grant", 1, xa + 32'h4, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0,0,0,0,0,0);
        #1 check_out("rstseq in reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(0,0,0,0,1,32'hDEAD_BEEF);
        #1 check_out("rstseq idle", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0,0,0,0,1,32'hDEAD_BEEF);
        #1 check_out("rstseq first req", 1, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0,0,0,0,0,0);
        #1 check_out("rstseq after stale", 1, 32'h0, 0, 0, 0, 0);

        // Randomized run against the reference model.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_pc = 32'h0; m_bi = '0; m_bp = '0; m_warm = 0; m_pend = 0; m_stale = 0;
        m_bv = 0; m_trap = 0; m_delay = 0;
        for (int k = 0; k < 3000; k++) begin
            r_stall = ($urandom_range(0, 3) == 0);
            r_redir = ($urandom_range(0, 11) == 0);
            r_tgt   = $urandom & 32'h0000_0FFF;
            r_gnt   = ($urandom_range(0, 1) == 1);
            r_rdata = $urandom;
            r_rv    = m_pend ? (m_delay == 0) : ($urandom_range(0, 19) == 0);
            drive(r_stall, r_redir, r_tgt, r_gnt, r_rv, r_rdata);
            #1;
            exp_req = m_warm && !m_pend && (!m_bv || !r_stall);
            check_out($sformatf("rnd%0d", k), exp_req, m_pc, m_bv, m_bi, m_bp, m_trap);

            acc  = exp_req && r_gnt;
            resp = m_pend && r_rv;
            live = resp && !m_stale && !r_redir;
            mis  = TRAP_EN && (r_tgt[1:0] != 2'b00);
            etgt = mis ? TRAP_VEC : {r_tgt[31:2], 2'b00};
            m_trap = r_redir && mis;
            if (r_redir) m_bv = 0;
            else if (live) begin m_bv = 1; m_bi = r_rdata; m_bp = m_pc; end
            else if (m_bv && !r_stall) m_bv = 0;
            if (r_redir) m_pc = etgt;
            else if (live) m_pc = m_pc + 32'h4;
            if (acc) begin
                m_pend = 1; m_stale = r_redir; m_delay = $urandom_range(0, 2);
            end else if (resp) begin
                m_pend = 0; m_stale = 0;
            end else begin
                if (r_redir && m_pend) m_stale = 1;
                if (m_pend) m_delay--;
            end
            m_warm = 1;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the architectural PC and sequences instruction fetch over a request/grant/response instruction-memory interface.
- Applies branch/jump redirects from execute and discards in-flight responses made stale by a redirect.
- Holds fetched instructions in a one-entry output buffer until decode accepts them.
- Sits between the PC/next-PC datapath and decode; replaces free-running PC increment with a stall- and latency-aware controller.

Parameters:
- WIDTH, 32, address/PC width.
- RESET_VECTOR, 32'h0000_0000, PC after reset.
- TRAP_VECTOR, 32'h0000_0010, PC loaded on misaligned redirect (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_target  in  WIDTH  new PC (branch target or jump-register result).
- stall  in  1  decode cannot accept instr this cycle.
- imem_req  out  1  fetch request valid.
- imem_addr  out  WIDTH  fetch address (equals current PC).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  response instruction.
- instr_valid  out  1  output buffer holds an instruction.
- instr  out  32  buffered instruction.
- instr_pc  out  WIDTH  PC of buffered instruction.
- misalign_trap  out  1  one-cycle pulse on misaligned redirect (tied 0 without macro).

Behaviour:
- Clock and reset: one clock, clk; asynchronous active-low reset rst.
- Reset values: pc=RESET_VECTOR, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0, misalign_trap=0.
- Outstanding requests: at most one; imem_addr=pc whenever imem_req=1.
- States IDLE, REQ, WAIT, DISCARD:
  - IDLE: one cycle after reset release, then REQ. First imem_req is the 2nd rising edge after rst deasserts.
  - REQ: imem_req=1 only when buffer free (!instr_valid, or instr_valid && !stall this cycle); else imem_req=0 and stay REQ. On imem_req && imem_gnt -> WAIT.
  - WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (wraps modulo 2^WIDTH), -> REQ.
  - DISCARD: imem_req=0. On imem_rvalid the data is dropped with no buffer write and no pc increment, -> REQ.
- Buffer: instr_valid clears on instr_valid && !stall unless refilled the same cycle. instr and instr_pc hold stable while instr_valid && stall.
- Minimum latency: gnt at cycle N, rvalid at N+1, instr_valid at N+2. Back-to-back throughput is one instruction per 2 cycles.
- Redirect has priority over stall and over any response. On redirect_valid: pc<=target and instr_valid<=0 (flush).
  - In REQ without gnt: stay REQ; new address is driven next cycle.
  - In REQ with gnt, or in WAIT without rvalid: -> DISCARD.
  - In WAIT with rvalid the same cycle: response dropped, -> REQ.
  - In DISCARD: pc updated, stay DISCARD.
  - In IDLE: pc updated.
- Reset mid-operation clears all state immediately. An in-flight response that arrives after reset release is ignored, because IDLE/REQ does not sample imem_rvalid.
- imem_rvalid in REQ or IDLE is a protocol error: ignored.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_target[1:0]!=0 loads pc<=TRAP_VECTOR instead of the target, and misalign_trap=1 for exactly the cycle after the redirect. Flush and DISCARD rules are unchanged.
- Undefined: redirect_target[1:0] is forced to 2'b00 and misalign_trap is constant 0.

Decomposition:
- Package fetch_pkg: enum fetch_state_t {IDLE, REQ, WAIT, DISCARD}; localparam INSTR_BYTES=4; default RESET_VECTOR/TRAP_VECTOR constants.
- One sub-module, fetch_out_buf: instr/instr_pc/instr_valid register with load, consume (valid && !stall) and flush inputs. The FSM and pc register stay in fetch_sequencer.

Test Plan:
- Reset release, gnt immediate, rvalid 1 cycle later, stall=0 -> imem_addr 0x0,0x4,0x8 and instr_valid with instr_pc 0x0,0x4,0x8 every 2 cycles.
- stall=1 for 5 cycles with buffer full (instr_pc=0x4) -> instr and instr_pc stable, imem_req=0. Release stall -> next imem_addr=0x8.
- Redirect to 0x100 while in WAIT (rvalid 3 cycles later) -> response dropped, instr_valid=0, next imem_addr=0x100, next instr_pc=0x100.
- Redirect to 0x200 in the same cycle as rvalid and stall=1 -> buffer flushed, rvalid data not written, imem_addr=0x200 next.
- rst asserted in WAIT, released, stale rvalid arrives -> ignored; first imem_addr=RESET_VECTOR.
- With FETCH_MISALIGN_TRAP_EN: redirect to 0x102 -> imem_addr=0x10, misalign_trap pulses 1 cycle. Without: imem_addr=0x100.
